// File: rtl/fetch_branch_predict.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit counters.
// Trained and redirected by branch resolution from EX.
module fetch_branch_predict #(
  parameter int unsigned BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  output logic [31:0] pc_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  output logic        flush_o,
  input  logic        ex_valid_i,
  input  logic        ex_is_branch_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_target_i
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [31:0]            pc_q, pc_d;
  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_d [BTB_ENTRIES];
  logic [31:0]            tgt_q [BTB_ENTRIES];
  logic [31:0]            tgt_d [BTB_ENTRIES];
  logic [1:0]             ctr_q [BTB_ENTRIES];
  logic [1:0]             ctr_d [BTB_ENTRIES];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit;
  logic             mispredict;
  logic [31:0]      redirect_pc;

  assign f_idx = pc_q[IDX_W+1:2];
  assign f_tag = pc_q[31:IDX_W+2];
  assign f_hit = valid_q[f_idx] & (tag_q[f_idx] == f_tag);

  assign pc_o          = pc_q;
  assign pred_taken_o  = f_hit & ctr_q[f_idx][1];
  assign pred_target_o = pred_taken_o ? tgt_q[f_idx]
                                      : pc_q + 32'd4;

  assign u_idx = ex_pc_i[IDX_W+1:2];
  assign u_tag = ex_pc_i[31:IDX_W+2];
  assign u_hit = valid_q[u_idx] & (tag_q[u_idx] == u_tag);

  // A non-branch predicted taken hit a stale aliasing entry.
  always_comb begin
    mispredict = 1'b0;
    if (ex_valid_i) begin
      if (ex_is_branch_i) begin
        mispredict = (ex_taken_i != ex_pred_taken_i)
                   | (ex_taken_i
                      & (ex_target_i != ex_pred_target_i));
      end else begin
        mispredict = ex_pred_taken_i;
      end
    end
  end

  assign flush_o     = mispredict;
  assign redirect_pc = (ex_taken_i & ex_is_branch_i) ? ex_target_i
                                                     : ex_pc_i + 32'd4;

  always_comb begin
    if (mispredict) begin
      pc_d = redirect_pc;
    end else if (stall_i) begin
      pc_d = pc_q;
    end else begin
      pc_d = pred_target_o;
    end
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (ex_valid_i) begin
      if (ex_is_branch_i & u_hit) begin
        if (ex_taken_i) begin
          if (ctr_q[u_idx] != 2'b11) begin
            ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
          end
          tgt_d[u_idx] = ex_target_i;
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
        end
      end else if (ex_is_branch_i & ex_taken_i) begin
        valid_d[u_idx] = 1'b1;
        tag_d[u_idx]   = u_tag;
        tgt_d[u_idx]   = ex_target_i;
        ctr_d[u_idx]   = 2'b10;
      end else if (!ex_is_branch_i & u_hit) begin
        valid_d[u_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= RESET_PC;
      valid_q <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk_i) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
    ctr_q <= ctr_d;
  end

endmodule

// File: tb/tb_fetch_branch_predict.sv
// Self-checking bench for fetch_branch_predict: directed
// scenarios plus random EX traffic against a behavioural model.
module tb_fetch_branch_predict;

  localparam int N = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        stall_i;
  logic [31:0] pc_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        flush_o;
  logic        ex_valid_i;
  logic        ex_is_branch_i;
  logic [31:0] ex_pc_i;
  logic        ex_taken_i;
  logic [31:0] ex_target_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_pred_target_i;

  int checks = 0;
  int errors = 0;

  fetch_branch_predict #(
    .BTB_ENTRIES(N),
    .RESET_PC(32'h0)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .stall_i(stall_i),
    .pc_o(pc_o),
    .pred_taken_o(pred_taken_o),
    .pred_target_o(pred_target_o),
    .flush_o(flush_o),
    .ex_valid_i(ex_valid_i),
    .ex_is_branch_i(ex_is_branch_i),
    .ex_pc_i(ex_pc_i),
    .ex_taken_i(ex_taken_i),
    .ex_target_i(ex_target_i),
    .ex_pred_taken_i(ex_pred_taken_i),
    .ex_pred_target_i(ex_pred_target_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural model: entry chosen by word address mod N,
  // tag is the word address divided by N, counter is an int 0..3.
  logic [31:0] m_pc;
  bit          m_valid [N];
  logic [31:0] m_tag [N];
  logic [31:0] m_tgt [N];
  int          m_ctr [N];

  function automatic int slot(logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic logic [31:0] tagof(logic [31:0] pc);
    return pc / (4 * N);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == tagof(pc));
  endfunction

  function automatic bit m_ptaken();
    return m_hit(m_pc) && (m_ctr[slot(m_pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptarget();
    logic [31:0] nxt;
    nxt = m_pc + 32'd4;
    if (m_ptaken()) nxt = m_tgt[slot(m_pc)];
    return nxt;
  endfunction

  function automatic bit m_flush();
    bit f;
    f = 1'b0;
    if (ex_valid_i && ex_is_branch_i) begin
      if (ex_taken_i != ex_pred_taken_i) f = 1'b1;
      if (ex_taken_i && ex_target_i != ex_pred_target_i) f = 1'b1;
    end
    if (ex_valid_i && !ex_is_branch_i && ex_pred_taken_i) f = 1'b1;
    return f;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_pc <= 32'h0;
      for (int i = 0; i < N; i++) m_valid[i] <= 1'b0;
    end else begin
      if (m_flush()) begin
        if (ex_is_branch_i && ex_taken_i) m_pc <= ex_target_i;
        else m_pc <= ex_pc_i + 32'd4;
      end else if (!stall_i) begin
        m_pc <= m_ptarget();
      end
      if (ex_valid_i) begin
        if (ex_is_branch_i && m_hit(ex_pc_i)) begin
          if (ex_taken_i) begin
            m_ctr[slot(ex_pc_i)] <=
              (m_ctr[slot(ex_pc_i)] < 3) ? m_ctr[slot(ex_pc_i)] + 1 : 3;
            m_tgt[slot(ex_pc_i)] <= ex_target_i;
          end else begin
            m_ctr[slot(ex_pc_i)] <=
              (m_ctr[slot(ex_pc_i)] > 0) ? m_ctr[slot(ex_pc_i)] - 1 : 0;
          end
        end else if (ex_is_branch_i && ex_taken_i) begin
          m_valid[slot(ex_pc_i)] <= 1'b1;
          m_tag[slot(ex_pc_i)]   <= tagof(ex_pc_i);
          m_tgt[slot(ex_pc_i)]   <= ex_target_i;
          m_ctr[slot(ex_pc_i)]   <= 2;
        end else if (!ex_is_branch_i && m_hit(ex_pc_i)) begin
          m_valid[slot(ex_pc_i)] <= 1'b0;
        end
      end
    end
  end

  task automatic set_ex(input bit v, input bit br,
                        input logic [31:0] pc, input bit tk,
                        input logic [31:0] tg, input bit ptk,
                        input logic [31:0] ptg);
    ex_valid_i       = v;
    ex_is_branch_i   = br;
    ex_pc_i          = pc;
    ex_taken_i       = tk;
    ex_target_i      = tg;
    ex_pred_taken_i  = ptk;
    ex_pred_target_i = ptg;
  endtask

  task automatic clear_ex();
    set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  // Present one EX report for a cycle, then sample after the edge.
  task automatic report(input bit br, input logic [31:0] pc,
                        input bit tk, input logic [31:0] tg,
                        input bit ptk, input logic [31:0] ptg);
    set_ex(1, br, pc, tk, tg, ptk, ptg);
    @(negedge clk_i);
    clear_ex();
    #1;
  endtask

  // A non-branch predicted taken forces a redirect to pc.
  task automatic goto(input logic [31:0] pc);
    report(0, pc - 32'd4, 0, 32'h0, 1, 32'h0);
  endtask

  task automatic test_reset();
    rst_ni  = 1'b0;
    stall_i = 1'b0;
    clear_ex();
    @(negedge clk_i);
    #1;
    checks++;
    if (pc_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc: got %h want 0", pc_o);
    end
    checks++;
    if (pred_target_o !== 32'h4 || pred_taken_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_pred: got %b/%h want 0/4",
               pred_taken_o, pred_target_o);
    end
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pc_o !== 32'(4 * i) || pred_taken_o !== 1'b0
          || flush_o !== 1'b0) begin
        errors++;
        $display("FAIL seq_pc%0d: got %h/%b/%b want %h/0/0",
                 i, pc_o, pred_taken_o, flush_o, 4 * i);
      end
      @(negedge clk_i);
      #1;
    end
  endtask

  task automatic test_allocate();
    set_ex(1, 1, 32'h10, 1, 32'h40, 0, 32'h14);
    #1;
    checks++;
    if (flush_o !== 1'b1) begin
      errors++;
      $display("FAIL alloc_flush: got %b want 1", flush_o);
    end
    @(negedge clk_i);
    clear_ex();
    #1;
    checks++;
    if (pc_o !== 32'h40) begin
      errors++;
      $display("FAIL alloc_redirect: got %h want 40", pc_o);
    end
    goto(32'h10);
    checks++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h40) begin
      errors++;
      $display("FAIL alloc_predict: got %b/%h want 1/40",
               pred_taken_o, pred_target_o);
    end
    @(negedge clk_i);
    #1;
    checks++;
    if (pc_o !== 32'h40) begin
      errors++;
      $display("FAIL alloc_follow: got %h want 40", pc_o);
    end
  endtask

  task automatic test_counter();
    set_ex(1, 1, 32'h10, 0, 32'h40, 1, 32'h40);
    #1;
    checks++;
    if (flush_o !== 1'b1) begin
      errors++;
      $display("FAIL ctr_flush: got %b want 1", flush_o);
    end
    @(negedge clk_i);
    clear_ex();
    #1;
    checks++;
    if (pc_o !== 32'h14) begin
      errors++;
      $display("FAIL ctr_redirect: got %h want 14", pc_o);
    end
    goto(32'h10);
    checks++;
    if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h14) begin
      errors++;
      $display("FAIL ctr_weak_nt: got %b/%h want 0/14",
               pred_taken_o, pred_target_o);
    end
    for (int i = 0; i < 3; i++) report(1, 32'h10, 1, 32'h40, 0, 32'h0);
    report(1, 32'h10, 0, 32'h40, 1, 32'h40);
    goto(32'h10);
    checks++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h40) begin
      errors++;
      $display("FAIL ctr_retrain: got %b/%h want 1/40",
               pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_stall();
    goto(32'h8);
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      #1;
      checks++;
      if (pc_o !== 32'h8) begin
        errors++;
        $display("FAIL stall_hold%0d: got %h want 8", i, pc_o);
      end
    end
    set_ex(1, 1, 32'h30, 1, 32'h80, 0, 32'h0);
    #1;
    checks++;
    if (flush_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_flush: got %b want 1", flush_o);
    end
    @(negedge clk_i);
    clear_ex();
    #1;
    checks++;
    if (pc_o !== 32'h80) begin
      errors++;
      $display("FAIL stall_redirect: got %h want 80", pc_o);
    end
    @(negedge clk_i);
    #1;
    checks++;
    if (pc_o !== 32'h80) begin
      errors++;
      $display("FAIL stall_after: got %h want 80", pc_o);
    end
    stall_i = 1'b0;
  endtask

  task automatic test_alias();
    goto(32'h50);
    checks++;
    if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h54) begin
      errors++;
      $display("FAIL alias_miss: got %b/%h want 0/54",
               pred_taken_o, pred_target_o);
    end
    report(1, 32'h50, 1, 32'h90, 0, 32'h0);
    goto(32'h10);
    checks++;
    if (pred_taken_o !== 1'b0) begin
      errors++;
      $display("FAIL alias_evict: got %b want 0", pred_taken_o);
    end
    goto(32'h50);
    checks++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h90) begin
      errors++;
      $display("FAIL alias_new: got %b/%h want 1/90",
               pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_same_cycle();
    set_ex(1, 1, 32'h50, 1, 32'hA0, 1, 32'hA0);
    #1;
    checks++;
    if (flush_o !== 1'b0 || pred_target_o !== 32'h90) begin
      errors++;
      $display("FAIL rw_old: got %b/%h want 0/90",
               flush_o, pred_target_o);
    end
    @(negedge clk_i);
    clear_ex();
    #1;
    checks++;
    if (pc_o !== 32'h90) begin
      errors++;
      $display("FAIL rw_follow: got %h want 90", pc_o);
    end
    goto(32'h50);
    checks++;
    if (pred_target_o !== 32'hA0) begin
      errors++;
      $display("FAIL rw_new: got %h want a0", pred_target_o);
    end
  endtask

  task automatic test_wrap();
    report(1, 32'h100, 1, 32'hFFFF_FFFC, 0, 32'h0);
    checks++;
    if (pc_o !== 32'hFFFF_FFFC || pred_target_o !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pred: got %h/%h want fffffffc/0",
               pc_o, pred_target_o);
    end
    @(negedge clk_i);
    #1;
    checks++;
    if (pc_o !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc: got %h want 0", pc_o);
    end
  endtask

  task automatic test_async_reset();
    report(1, 32'h10, 1, 32'h40, 0, 32'h0);
    goto(32'h10);
    checks++;
    if (pred_taken_o !== 1'b1) begin
      errors++;
      $display("FAIL arst_learned: got %b want 1", pred_taken_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (pc_o !== 32'h0) begin
      errors++;
      $display("FAIL arst_pc: got %h want 0", pc_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    goto(32'h10);
    checks++;
    if (pred_taken_o !== 1'b0) begin
      errors++;
      $display("FAIL arst_forgot: got %b want 0", pred_taken_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      stall_i = ($urandom_range(0, 3) == 0);
      set_ex($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
             {24'h0, 6'($urandom_range(0, 63)), 2'b00},
             1'($urandom), {24'h0, 6'($urandom_range(0, 63)), 2'b00},
             1'($urandom), {24'h0, 6'($urandom_range(0, 63)), 2'b00});
      #1;
      checks++;
      if (pc_o !== m_pc) begin
        errors++;
        $display("FAIL rnd_pc@%0d: got %h want %h", i, pc_o, m_pc);
      end
      checks++;
      if (pred_taken_o !== m_ptaken()) begin
        errors++;
        $display("FAIL rnd_ptaken@%0d: got %b want %b",
                 i, pred_taken_o, m_ptaken());
      end
      checks++;
      if (pred_target_o !== m_ptarget()) begin
        errors++;
        $display("FAIL rnd_ptarget@%0d: got %h want %h",
                 i, pred_target_o, m_ptarget());
      end
      checks++;
      if (flush_o !== m_flush()) begin
        errors++;
        $display("FAIL rnd_flush@%0d: got %b want %b",
                 i, flush_o, m_flush());
      end
    end
    stall_i = 1'b0;
    clear_ex();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_allocate();
    test_counter();
    test_stall();
    test_alias();
    test_same_cycle();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
